// File: rtl/cnn_pkg.sv
// Constants and result record shared by the CNN data controller and the accumulator collector.
package cnn_pkg;

    localparam int CNT_MAX    = 32;
    localparam int POS_MAX    = 9;
    localparam int DW         = 16;
    localparam int AW         = 20;
    localparam int FIFO_DEPTH = 4;
    localparam int CW         = 5;
    localparam int PW         = 4;

    typedef struct packed {
        logic [CW-1:0]        idx;
        logic signed [AW-1:0] sum;
    } result_t;

    function automatic logic signed [AW-1:0] sext(input logic signed [DW-1:0] d);
        return {{(AW-DW){d[DW-1]}}, d};
    endfunction

endpackage

// File: rtl/cnn_result_fifo.sv
// Synchronous result FIFO with a registered head; a push into an empty FIFO shows at head one cycle later.
// Pushes while full are dropped, so the writer must gate on full.
module cnn_result_fifo
    import cnn_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH
)
(
    input  logic    clk,
    input  logic    rst_b,
    input  logic    push,
    input  result_t push_dat,
    input  logic    pop,
    output result_t head,
    output logic    full,
    output logic    empty
);

    localparam int PTRW = $clog2(DEPTH);
    localparam int CNTW = $clog2(DEPTH + 1);

    result_t         mem [DEPTH];
    logic [PTRW-1:0] wr_ptr;
    logic [PTRW-1:0] rd_ptr;
    logic [PTRW-1:0] rd_ptr_nxt;
    logic [CNTW-1:0] count;
    logic            do_push;
    logic            do_pop;

    assign full       = (count == CNTW'(DEPTH));
    assign empty      = (count == '0);
    assign do_push    = push && !full;
    assign do_pop     = pop && !empty;
    assign rd_ptr_nxt = rd_ptr + 1'b1;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            head   <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr_nxt;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
            // Head tracks the next entry to leave; the incoming record bypasses memory when it becomes head.
            if (do_push && (empty || (do_pop && count == CNTW'(1)))) begin
                head <= push_dat;
            end else if (do_pop && count > CNTW'(1)) begin
                head <= mem[rd_ptr_nxt];
            end
        end
    end

endmodule

// File: rtl/cnn_accum_collector.sv
// Sums 9 taps per lane from the cnt/pos sweep and queues finished lane sums; result visible 1 cycle after the last tap.
// in_ready drops for every beat while the result FIFO is full; a sticky flag reports sweep-order errors.
module cnn_accum_collector
    import cnn_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_b,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic signed [DW-1:0] in_data,
    input  logic [CW-1:0]        in_cnt,
    input  logic [PW-1:0]        in_pos,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic signed [AW-1:0] out_data,
    output logic [CW-1:0]        out_idx,
    output logic                 seq_err,
    input  logic                 clr_err
);

    logic signed [AW-1:0] acc [CNT_MAX];
    logic signed [AW-1:0] data_ext;
    logic signed [AW-1:0] sum_nxt;
    logic                 accept;
    logic                 last_tap;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 seq_ok;
    logic [CW-1:0]        exp_cnt;
    logic [PW-1:0]        exp_pos;
    logic [CW-1:0]        nxt_cnt;
    logic [PW-1:0]        nxt_pos;
    result_t              res_in;
    result_t              res_head;

    assign in_ready = !fifo_full;
    assign accept   = in_valid && in_ready;
    assign last_tap = (in_pos == PW'(POS_MAX - 1));
    assign data_ext = sext(in_data);
    assign sum_nxt  = (in_pos == '0) ? data_ext : acc[in_cnt] + data_ext;
    assign res_in   = {in_cnt, sum_nxt};

    always_ff @(posedge clk) begin
        if (accept) begin
            acc[in_cnt] <= sum_nxt;
        end
    end

    // Advance from the received indices, so a mismatch resynchronises the checker to the stream.
    always_comb begin
        nxt_cnt = in_cnt + 1'b1;
        nxt_pos = in_pos;
        if (in_cnt == CW'(CNT_MAX - 1)) begin
            nxt_cnt = '0;
            nxt_pos = (in_pos >= PW'(POS_MAX - 1)) ? '0 : in_pos + 1'b1;
        end
    end

    assign seq_ok = (in_cnt == exp_cnt) && (in_pos == exp_pos);

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            exp_cnt <= '0;
            exp_pos <= '0;
            seq_err <= 1'b0;
        end else begin
            if (accept) begin
                exp_cnt <= nxt_cnt;
                exp_pos <= nxt_pos;
            end
            if (accept && !seq_ok) begin
                seq_err <= 1'b1;
            end else if (clr_err) begin
                seq_err <= 1'b0;
            end
        end
    end

    cnn_result_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_b    (rst_b),
        .push     (accept && last_tap),
        .push_dat (res_in),
        .pop      (out_valid && out_ready),
        .head     (res_head),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    assign out_valid = !fifo_empty;
    assign out_data  = res_head.sum;
    assign out_idx   = res_head.idx;

endmodule
